// File: rtl/ace_snapshot_loader_if.sv
// ioctl byte stream between data_io and the Jupiter Ace snapshot loader.
interface ace_snapshot_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [7:0]  ioctl_dout;
  logic [15:0] ioctl_addr;
  logic        ioctl_wait;

  modport master (
    output ioctl_download,
    output ioctl_index,
    output ioctl_wr,
    output ioctl_dout,
    output ioctl_addr,
    input  ioctl_wait
  );

  modport slave (
    input  ioctl_download,
    input  ioctl_index,
    input  ioctl_wr,
    input  ioctl_dout,
    input  ioctl_addr,
    output ioctl_wait
  );
endinterface

// File: rtl/ace_snapshot_loader.sv
// Jupiter Ace .DCE snapshot loader feeding the ace RAM loader port.
// ACE_RLE_EN selects ED-escape RLE decoding; undefined gives raw pass-through.
module ace_snapshot_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h2000,
  parameter int unsigned WR_GAP    = 1
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  ace_snapshot_loader_if.slave        ioc,
  output logic [15:0]                 loader_addr,
  output logic [7:0]                  loader_data,
  output logic                        loader_wr,
  output logic                        loader_en,
  output logic                        loader_reset,
  output logic                        overflow,
  output logic                        overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_LIT, S_ESC, S_VAL, S_RUN, S_END, S_DRAIN
  } state_t;

  localparam logic [7:0] GAP = 8'(WR_GAP);

  state_t      state, nstate;
  logic        dl_q, rise, fall, start, restart;
  logic        issue, busy;
  logic [16:0] iaddr;
  logic [7:0]  idata;
  logic [7:0]  gap;
  logic [4:0]  ext;

  assign rise    = ioc.ioctl_download & ~dl_q;
  assign fall    = ~ioc.ioctl_download & dl_q;
  assign start   = rise & (ioc.ioctl_index == 8'd1);
  assign restart = start & ((state == S_IDLE) | (state == S_DRAIN));

`ifdef ACE_RLE_EN
  localparam logic [7:0] ESC_B = 8'hED;

  logic [16:0] cnt;
  logic [7:0]  run, val, pdata;
  logic        pend, byte_ok, lit, stash;
  logic        unused_addr;

  assign unused_addr    = ^ioc.ioctl_addr;
  assign ioc.ioctl_wait = (state == S_RUN) | pend;
  assign byte_ok = ioc.ioctl_wr & ~ioc.ioctl_wait;
  assign lit     = (state == S_LIT) & ~fall & byte_ok
                 & (ioc.ioctl_dout != ESC_B);
  assign stash   = lit & (gap != 8'd0);
  assign busy    = pend | loader_wr | (gap != 8'd0);

  // a literal arriving inside the spacing window waits in pdata
  always_comb begin
    issue = 1'b0;
    idata = ioc.ioctl_dout;
    iaddr = cnt;
    unique case (1'b1)
      (state == S_RUN) && (gap == 8'd0): begin
        issue = 1'b1;
        idata = val;
      end
      pend && (gap == 8'd0): begin
        issue = 1'b1;
        idata = pdata;
      end
      lit && (gap == 8'd0): issue = 1'b1;
      default: ;
    endcase
  end
`else
  assign ioc.ioctl_wait = 1'b0;
  assign busy = loader_wr | (gap != 8'd0);

  always_comb begin
    issue = (state == S_LIT) & ioc.ioctl_wr;
    idata = ioc.ioctl_dout;
    iaddr = {1'b0, ioc.ioctl_addr} + {1'b0, BASE_ADDR};
  end
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (restart) begin
      nstate = S_LIT;
    end else begin
      unique case (state)
        S_IDLE: ;
`ifdef ACE_RLE_EN
        S_LIT:
          if (fall) nstate = S_DRAIN;
          else if (byte_ok && ioc.ioctl_dout == ESC_B) nstate = S_ESC;
        S_ESC:
          if (fall) nstate = S_DRAIN;
          else if (byte_ok)
            nstate = (ioc.ioctl_dout == 8'd0) ? S_END : S_VAL;
        S_VAL:
          if (fall) nstate = S_DRAIN;
          else if (byte_ok) nstate = S_RUN;
        S_RUN:
          if (issue && run == 8'd1)
            nstate = ioc.ioctl_download ? S_LIT : S_DRAIN;
        S_END:
          if (!ioc.ioctl_download) nstate = S_DRAIN;
`else
        S_LIT:
          if (fall) nstate = S_DRAIN;
`endif
        S_DRAIN:
          if (!busy) nstate = S_IDLE;
        default: nstate = S_IDLE;
      endcase
    end
  end

  always_comb begin
    loader_en    = (state != S_IDLE);
    loader_reset = loader_en | (ext != 5'd0);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q        <= 1'b0;
      gap         <= 8'd0;
      ext         <= 5'd0;
      loader_wr   <= 1'b0;
      loader_addr <= 16'd0;
      loader_data <= 8'd0;
      overflow    <= 1'b0;
      overrun     <= 1'b0;
`ifdef ACE_RLE_EN
      cnt   <= {1'b0, BASE_ADDR};
      run   <= 8'd0;
      val   <= 8'd0;
      pdata <= 8'd0;
      pend  <= 1'b0;
`endif
    end else begin
      dl_q      <= ioc.ioctl_download;
      loader_wr <= issue & ~iaddr[16];
      if (issue) begin
        loader_addr <= iaddr[15:0];
        loader_data <= idata;
      end
      if (issue) gap <= GAP;
      else if (gap != 8'd0) gap <= gap - 8'd1;
      if (state == S_DRAIN && nstate == S_IDLE) ext <= 5'd16;
      else if (ext != 5'd0) ext <= ext - 5'd1;
      if (issue & iaddr[16]) overflow <= 1'b1;
`ifdef ACE_RLE_EN
      if (ioc.ioctl_wr & ioc.ioctl_wait) overrun <= 1'b1;
      if (issue) cnt <= cnt[16] ? cnt : cnt + 17'd1;
      if (stash) begin
        pend  <= 1'b1;
        pdata <= ioc.ioctl_dout;
      end else if (issue) begin
        pend <= 1'b0;
      end
      if (state == S_ESC && byte_ok && !fall) run <= ioc.ioctl_dout;
      else if (state == S_RUN && issue) run <= run - 8'd1;
      // first run write keeps the full gap after the value byte
      if (state == S_VAL && byte_ok && !fall) begin
        val <= ioc.ioctl_dout;
        gap <= GAP;
      end
`else
      overrun <= 1'b0;
`endif
      if (restart) begin
        overflow <= 1'b0;
        overrun  <= 1'b0;
        ext      <= 5'd0;
`ifdef ACE_RLE_EN
        cnt  <= {1'b0, BASE_ADDR};
        pend <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ace_snapshot_loader.sv
// Directed bench for ace_snapshot_loader; second instance sits near 16'hFFFF.
// Covers whichever build (ACE_RLE_EN or pass-through) is compiled.
`timescale 1ns/1ps
module tb_ace_snapshot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        dl;
  logic [7:0]  idx;
  logic        wr;
  logic [7:0]  dout;
  logic [15:0] addr;

  ace_snapshot_loader_if ifa();
  ace_snapshot_loader_if ifb();

  assign ifa.ioctl_download = dl;
  assign ifa.ioctl_index    = idx;
  assign ifa.ioctl_wr       = wr;
  assign ifa.ioctl_dout     = dout;
  assign ifa.ioctl_addr     = addr;
  assign ifb.ioctl_download = dl;
  assign ifb.ioctl_index    = idx;
  assign ifb.ioctl_wr       = wr;
  assign ifb.ioctl_dout     = dout;
  assign ifb.ioctl_addr     = addr;

  logic [15:0] a_addr, b_addr;
  logic [7:0]  a_data, b_data;
  logic        a_wr, a_en, a_rst, a_ovf, a_ovr;
  logic        b_wr, b_en, b_rst, b_ovf, b_ovr;

  ace_snapshot_loader u_a (
    .clk_sys(clk), .reset(reset), .ioc(ifa),
    .loader_addr(a_addr), .loader_data(a_data), .loader_wr(a_wr),
    .loader_en(a_en), .loader_reset(a_rst),
    .overflow(a_ovf), .overrun(a_ovr)
  );

  ace_snapshot_loader #(.BASE_ADDR(16'hFFF0), .WR_GAP(1)) u_b (
    .clk_sys(clk), .reset(reset), .ioc(ifb),
    .loader_addr(b_addr), .loader_data(b_data), .loader_wr(b_wr),
    .loader_en(b_en), .loader_reset(b_rst),
    .overflow(b_ovf), .overrun(b_ovr)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int waitc = 0;
  int b_cnt = 0;
  int ext_len;
  logic [15:0] b_la = 16'd0;
  logic [7:0]  b_ld = 8'd0;
  logic [15:0] wa[$];
  logic [7:0]  wd[$];
  int          wt[$];
  int          st[$];

  always @(negedge clk) begin
    if (a_wr === 1'b1) begin
      wa.push_back(a_addr);
      wd.push_back(a_data);
      wt.push_back(cyc);
    end
    if (wr === 1'b1) st.push_back(cyc);
    if (ifa.ioctl_wait === 1'b1) waitc++;
    if (b_wr === 1'b1) begin
      b_cnt++;
      b_la = b_addr;
      b_ld = b_data;
    end
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    wa.delete();
    wd.delete();
    wt.delete();
    st.delete();
    waitc = 0;
    b_cnt = 0;
  endtask

  task automatic send(logic [7:0] b, logic [15:0] a = 16'd0);
    int n = 0;
    while (ifa.ioctl_wait === 1'b1 && n < 600) begin
      tick();
      n++;
    end
    chk("stall_bound", 32'(n < 600), 32'd1);
    dout = b;
    addr = a;
    wr   = 1'b1;
    tick();
    wr = 1'b0;
    tick();
  endtask

  task automatic begin_dl();
    dl = 1'b1;
    tick(3);
  endtask

  task automatic end_dl(output int len);
    int n = 0;
    dl = 1'b0;
    while (a_en === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_bound", 32'(n < 100), 32'd1);
    len = 0;
    while (a_rst === 1'b1 && len < 100) begin
      tick();
      len++;
    end
  endtask

  task automatic chk_zero(string tag);
    chk(tag, 32'({a_wr, a_en, a_rst, ifa.ioctl_wait, a_ovf, a_ovr}), 32'd0);
    chk(tag, 32'({a_addr, a_data}), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    dl    = 1'b0;
    idx   = 8'd0;
    wr    = 1'b0;
    dout  = 8'd0;
    addr  = 16'd0;
    tick(3);
    chk_zero("in_reset");
    reset = 1'b0;
    tick(2);
    chk_zero("after_reset");

    // foreign index is ignored
    clr();
    idx = 8'd2;
    begin_dl();
    chk("foreign_en", 32'({a_en, a_rst}), 32'd0);
    send(8'h11);
    chk("foreign_wr", 32'(wa.size()), 32'd0);
    dl = 1'b0;
    tick(2);
    idx = 8'd1;

`ifdef ACE_RLE_EN
    // literals
    clr();
    begin_dl();
    chk("lit_en", 32'({a_en, a_rst}), 32'd3);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'hED);
    send(8'h00);
    chk("lit_cnt", 32'(wa.size()), 32'd3);
    chk("lit_w0", {16'd0, wa[0]}, 32'h2000);
    chk("lit_d0", {24'd0, wd[0]}, 32'h11);
    chk("lit_w1", {wa[1], 8'd0, wd[1]}, 32'h2001_0022);
    chk("lit_w2", {wa[2], 8'd0, wd[2]}, 32'h2002_0033);
    chk("lit_lat", 32'(wt[0] - st[0]), 32'd1);
    end_dl(ext_len);
    chk("lit_ext", 32'(ext_len), 32'd16);
    chk("lit_flags", 32'({a_ovf, a_ovr}), 32'd0);

    // run of five
    clr();
    begin_dl();
    send(8'hED);
    send(8'h05);
    send(8'hAA);
    send(8'hED);
    send(8'h00);
    end_dl(ext_len);
    chk("run_cnt", 32'(wa.size()), 32'd5);
    for (int i = 0; i < wa.size(); i++)
      chk("run_w", {wa[i], 8'd0, wd[i]},
          {16'h2000 + 16'(i), 16'h00AA});
    for (int i = 1; i < wt.size(); i++)
      chk("run_gap", 32'(wt[i] - wt[i-1]), 32'd2);
    chk("run_wait", 32'(waitc), 32'd10);

    // escaped ED then literal right behind a run
    clr();
    begin_dl();
    send(8'hED);
    send(8'h01);
    send(8'hED);
    send(8'h7F);
    send(8'hED);
    send(8'h00);
    end_dl(ext_len);
    chk("esc_cnt", 32'(wa.size()), 32'd2);
    chk("esc_w0", {wa[0], 8'd0, wd[0]}, 32'h2000_00ED);
    chk("esc_w1", {wa[1], 8'd0, wd[1]}, 32'h2001_007F);
    chk("esc_gap", 32'(wt[1] - wt[0] >= 2), 32'd1);

    // overflow on the FFF0-based instance
    clr();
    begin_dl();
    send(8'hED);
    send(8'h11);
    send(8'h55);
    send(8'hED);
    send(8'h00);
    end_dl(ext_len);
    chk("ovf_a_cnt", 32'(wa.size()), 32'd17);
    chk("ovf_a_flag", 32'(a_ovf), 32'd0);
    chk("ovf_b_cnt", 32'(b_cnt), 32'd16);
    chk("ovf_b_last", {b_la, 8'd0, b_ld}, 32'hFFFF_0055);
    chk("ovf_b_flag", 32'(b_ovf), 32'd1);

    // stall violation mid-run
    clr();
    begin_dl();
    chk("ovf_clear", 32'(b_ovf), 32'd0);
    send(8'hED);
    send(8'h08);
    send(8'h66);
    chk("ovr_wait", 32'(ifa.ioctl_wait), 32'd1);
    dout = 8'h99;
    wr   = 1'b1;
    tick();
    wr = 1'b0;
    chk("ovr_flag", 32'(a_ovr), 32'd1);
    tick();
    send(8'hED);
    send(8'h00);
    end_dl(ext_len);
    chk("ovr_cnt", 32'(wa.size()), 32'd8);
    chk("ovr_last", {wa[7], 8'd0, wd[7]}, 32'h2007_0066);
    for (int i = 0; i < wd.size(); i++)
      chk("ovr_data", {24'd0, wd[i]}, 32'h66);
    chk("ovr_sticky", 32'(a_ovr), 32'd1);

    // synchronous reset during a long run
    clr();
    begin_dl();
    chk("ovr_clear", 32'(a_ovr), 32'd0);
    send(8'hED);
    send(8'hFF);
    send(8'h55);
    tick(6);
    chk("rst_pre", 32'(wa.size() > 0), 32'd1);
    reset = 1'b1;
    tick();
    chk_zero("rst_mid");
    clr();
    dl = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(10);
    chk("rst_nowr", 32'(wa.size()), 32'd0);
    chk("rst_idle", 32'({a_en, a_rst, ifa.ioctl_wait}), 32'd0);
`else
    // raw pass-through
    clr();
    begin_dl();
    chk("pt_en", 32'({a_en, a_rst}), 32'd3);
    send(8'hED, 16'd0);
    send(8'h05, 16'd1);
    send(8'hAA, 16'd2);
    chk("pt_cnt", 32'(wa.size()), 32'd3);
    chk("pt_w0", {wa[0], 8'd0, wd[0]}, 32'h2000_00ED);
    chk("pt_w1", {wa[1], 8'd0, wd[1]}, 32'h2001_0005);
    chk("pt_w2", {wa[2], 8'd0, wd[2]}, 32'h2002_00AA);
    chk("pt_lat", 32'(wt[0] - st[0]), 32'd1);
    chk("pt_wait", 32'(waitc), 32'd0);
    end_dl(ext_len);
    chk("pt_ext", 32'(ext_len), 32'd16);

    // overflow on the FFF0-based instance
    clr();
    begin_dl();
    send(8'h12, 16'h000F);
    send(8'h34, 16'h0010);
    chk("pt_a_cnt", 32'(wa.size()), 32'd2);
    chk("pt_a_w0", {wa[0], 8'd0, wd[0]}, 32'h200F_0012);
    chk("pt_a_w1", {wa[1], 8'd0, wd[1]}, 32'h2010_0034);
    chk("pt_a_ovf", 32'(a_ovf), 32'd0);
    chk("pt_b_cnt", 32'(b_cnt), 32'd1);
    chk("pt_b_last", {b_la, 8'd0, b_ld}, 32'hFFFF_0012);
    chk("pt_b_ovf", 32'(b_ovf), 32'd1);
    chk("pt_ovr", 32'(a_ovr), 32'd0);
    end_dl(ext_len);

    // synchronous reset beats an incoming byte
    clr();
    begin_dl();
    chk("pt_ovf_clr", 32'(b_ovf), 32'd0);
    dout  = 8'h56;
    wr    = 1'b1;
    reset = 1'b1;
    tick();
    wr = 1'b0;
    chk_zero("pt_rst");
    dl = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(10);
    chk("pt_rst_nowr", 32'(wa.size()), 32'd0);
    chk("pt_rst_idle", 32'({a_en, a_rst}), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
